// File: rtl/writeback_queue.sv
// Writeback buffer: merges ALU and load results into a FIFO that drains one entry per cycle
// into the register file write port. Optional same-cycle bypass when WRITEBACK_BYPASS_EN is defined.
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [63:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [63:0]              mem_data,
  output logic                     mem_ready,
  input  logic                     wb_hold,
  output logic                     rd_write,
  output logic [4:0]               rd_addr,
  output logic [63:0]              rd_data,
  output logic [31:0]              busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_entry_t;

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic [CNT_W-1:0]   w_free;
  logic               w_alu_xfer;
  logic               w_mem_xfer;
  logic               w_alu_byp;
  logic               w_mem_byp;
  logic               w_alu_enq;
  logic               w_mem_enq;
  logic               w_deq;
  logic [PTR_W-1:0]   w_mem_slot;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_off;

  // Space check ignores a same-cycle dequeue; the ALU wins the last slot.
  assign w_free     = CNT_W'(DEPTH) - r_count;
  assign alu_ready  = (w_free >= CNT_W'(1));
  assign mem_ready  = (w_free >= CNT_W'(2)) || ((w_free == CNT_W'(1)) && !alu_valid);
  assign w_alu_xfer = alu_valid && alu_ready;
  assign w_mem_xfer = mem_valid && mem_ready;

`ifdef WRITEBACK_BYPASS_EN
  logic w_byp_ok;
  assign w_byp_ok  = (r_count == '0) && !wb_hold;
  assign w_alu_byp = w_byp_ok && w_alu_xfer && (alu_rd != 5'd0);
  assign w_mem_byp = w_byp_ok && !w_alu_byp && w_mem_xfer && (mem_rd != 5'd0);
`else
  assign w_alu_byp = 1'b0;
  assign w_mem_byp = 1'b0;
`endif

  // x0 writes complete the handshake but are dropped.
  assign w_alu_enq  = w_alu_xfer && (alu_rd != 5'd0) && !w_alu_byp;
  assign w_mem_enq  = w_mem_xfer && (mem_rd != 5'd0) && !w_mem_byp;
  assign w_deq      = (r_count != '0) && !wb_hold;
  assign w_mem_slot = r_tail + PTR_W'(w_alu_enq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_alu_enq) + PTR_W'(w_mem_enq);
      r_count <= r_count + CNT_W'(w_alu_enq) + CNT_W'(w_mem_enq) - CNT_W'(w_deq);
    end
  end

  // Storage needs no reset: only entries inside [head, head+count) are ever observed.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_alu_enq) r_mem[r_tail]     <= '{rd: alu_rd, data: alu_data};
      if (w_mem_enq) r_mem[w_mem_slot] <= '{rd: mem_rd, data: mem_data};
    end
  end

  always_comb begin
    rd_write = 1'b0;
    rd_addr  = 5'd0;
    rd_data  = 64'd0;
    if (rst_n) begin
      if (w_alu_byp) begin
        rd_write = 1'b1;
        rd_addr  = alu_rd;
        rd_data  = alu_data;
      end else if (w_mem_byp) begin
        rd_write = 1'b1;
        rd_addr  = mem_rd;
        rd_data  = mem_data;
      end else if (w_deq) begin
        rd_write = 1'b1;
        rd_addr  = r_mem[r_head].rd;
        rd_data  = r_mem[r_head].data;
      end
    end
  end

  // Pending-write vector: OR of destinations over occupied slots.
  always_comb begin
    busy  = 32'd0;
    w_idx = '0;
    w_off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = PTR_W'(i);
      w_off = w_idx - r_head;
      if (CNT_W'(w_off) < r_count) busy[r_mem[w_idx].rd] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  assign count = r_count;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue (DEPTH=4); bypass expectations
// are selected by WRITEBACK_BYPASS_EN.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic        wb_hold;
  logic        rd_write;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic [31:0] busy;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_hold(wb_hold), .rd_write(rd_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [63:0] md);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wb_hold = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_rd_write", 64'(rd_write), 0);
    chk("rst_rd_addr", 64'(rd_addr), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_alu_ready", 64'(alu_ready), 1);
    chk("rst_mem_ready", 64'(mem_ready), 1);

`ifndef WRITEBACK_BYPASS_EN
    // Single ALU result, one-cycle latency
    drive(1, 5'd5, 64'hDEAD_BEEF, 0, 0, 0);
    #1;
    chk("t1_alu_ready", 64'(alu_ready), 1);
    chk("t1_no_write_same_cycle", 64'(rd_write), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("t1_rd_write", 64'(rd_write), 1);
    chk("t1_rd_addr", 64'(rd_addr), 5);
    chk("t1_rd_data", rd_data, 64'hDEAD_BEEF);
    chk("t1_busy", 64'(busy), 64'h20);
    chk("t1_count1", 64'(count), 1);
    tick();
    chk("t1_busy_clear", 64'(busy), 0);
    chk("t1_count0", 64'(count), 0);
    chk("t1_idle", 64'(rd_write), 0);

    // Same rd on both channels retires ALU then mem
    drive(1, 5'd3, 64'd1, 1, 5'd3, 64'd2);
    #1;
    chk("t2_alu_ready", 64'(alu_ready), 1);
    chk("t2_mem_ready", 64'(mem_ready), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("t2_count", 64'(count), 2);
    chk("t2_w0_addr", 64'(rd_addr), 3);
    chk("t2_w0_data", rd_data, 1);
    chk("t2_busy", 64'(busy), 64'h8);
    tick();
    chk("t2_w1_write", 64'(rd_write), 1);
    chk("t2_w1_data", rd_data, 2);
    tick();
    chk("t2_empty", 64'(count), 0);
`else
    // Bypass: empty queue, ALU result written in the accept cycle
    drive(1, 5'd7, 64'h55, 0, 0, 0);
    #1;
    chk("byp_rd_write", 64'(rd_write), 1);
    chk("byp_rd_addr", 64'(rd_addr), 7);
    chk("byp_rd_data", rd_data, 64'h55);
    chk("byp_busy_same", 64'(busy), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("byp_count", 64'(count), 0);
    chk("byp_busy_after", 64'(busy), 0);
    // Both valid: ALU bypassed, mem enqueued
    drive(1, 5'd7, 64'h1, 1, 5'd9, 64'h2);
    #1;
    chk("byp2_addr", 64'(rd_addr), 7);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("byp2_count", 64'(count), 1);
    chk("byp2_busy", 64'(busy), 64'h200);
    chk("byp2_addr_q", 64'(rd_addr), 9);
    chk("byp2_data_q", rd_data, 2);
    tick();
    chk("byp2_empty", 64'(count), 0);
`endif

    // Hold: fill to full, then last-slot arbitration
    wb_hold = 1'b1;
    drive(1, 5'd1, 64'h11, 1, 5'd2, 64'h22);
    tick();
    chk("h_count2", 64'(count), 2);
    drive(1, 5'd3, 64'h33, 1, 5'd4, 64'h44);
    tick();
    drive(1, 5'd5, 64'h55, 1, 5'd6, 64'h66);
    #1;
    chk("h_count4", 64'(count), 4);
    chk("h_full_alu_ready", 64'(alu_ready), 0);
    chk("h_full_mem_ready", 64'(mem_ready), 0);
    chk("h_held_write", 64'(rd_write), 0);
    chk("h_held_addr", 64'(rd_addr), 0);
    chk("h_busy_full", 64'(busy), 64'h1E);
    wb_hold = 1'b0;
    #1;
    chk("h_full_deq_alu_ready", 64'(alu_ready), 0);
    chk("h_drain_addr", 64'(rd_addr), 1);
    chk("h_drain_data", rd_data, 64'h11);
    tick();
    wb_hold = 1'b1;
    #1;
    chk("h_count3", 64'(count), 3);
    chk("h_c3_alu_ready", 64'(alu_ready), 1);
    chk("h_c3_mem_ready", 64'(mem_ready), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wb_hold = 1'b0;
    #1;
    chk("h_count_after", 64'(count), 4);
    chk("h_busy_after", 64'(busy), 64'h3C);
    chk("h_d0", 64'(rd_addr), 2);
    tick();
    chk("h_d1", 64'(rd_addr), 3);
    tick();
    chk("h_d2", 64'(rd_addr), 4);
    tick();
    chk("h_d3", 64'(rd_addr), 5);
    chk("h_d3_data", rd_data, 64'h55);
    tick();
    chk("h_drained", 64'(count), 0);
    chk("h_drained_busy", 64'(busy), 0);

    // x0 destinations: accepted but dropped
    drive(1, 5'd0, 64'hAA, 1, 5'd0, 64'hBB);
    #1;
    chk("z_alu_ready", 64'(alu_ready), 1);
    chk("z_mem_ready", 64'(mem_ready), 1);
    chk("z_write_same", 64'(rd_write), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("z_count", 64'(count), 0);
    chk("z_write", 64'(rd_write), 0);
    chk("z_busy", 64'(busy), 0);

    // Reset with three pending entries
    wb_hold = 1'b1;
    drive(1, 5'd8, 64'h88, 1, 5'd9, 64'h99);
    tick();
    drive(1, 5'd10, 64'hA0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("r_count3", 64'(count), 3);
    rst_n = 1'b0;
    wb_hold = 1'b0;
    #1;
    chk("r_no_write_in_reset", 64'(rd_write), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("r_count0", 64'(count), 0);
    chk("r_busy0", 64'(busy), 0);
    chk("r_alu_ready", 64'(alu_ready), 1);
    chk("r_mem_ready", 64'(mem_ready), 1);
    chk("r_idle", 64'(rd_write), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers register writeback results from the ALU and load/store channels and drains them, one per cycle, into the 64-bit, 32-entry integer register file write port (`rd_addr`/`rd_data`/`rd_write`). It sits between the execute/memory stages and the register file, so both result sources can retire in the same cycle. It also publishes a per-register pending-write vector that the decode hazard logic uses to stall.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `alu_valid` in 1: ALU result present.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 64: ALU result.
- `alu_ready` out 1: ALU result accepted this cycle when `alu_valid` is also high.
- `mem_valid` in 1: load result present.
- `mem_rd` in 5: load destination register.
- `mem_data` in 64: load result.
- `mem_ready` out 1: load result accepted this cycle when `mem_valid` is also high.
- `wb_hold` in 1: freezes draining; the head entry stays.
- `rd_write` out 1: register file write enable.
- `rd_addr` out 5: register file write address.
- `rd_data` out 64: register file write data.
- `busy` out 32: bit r set while a write to xr is pending.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Circular FIFO of {rd[4:0], data[63:0]} with head/tail pointers and an occupancy counter. Pointers wrap modulo DEPTH.
- Free slots: `free` = DEPTH − `count`. A dequeue in the same cycle does not add a slot.
- `alu_ready` = (`free` ≥ 1).
- `mem_ready` = (`free` ≥ 2) || (`free` == 1 && !`alu_valid`). The ALU wins the last slot.
- Handshake: a transfer occurs when valid && ready at the rising edge. Sources hold rd/data stable until the transfer.
- Both channels may transfer in one cycle. The ALU entry is enqueued first (it is older), then the mem entry. Two writes to the same rd therefore retire ALU-then-mem, and mem's value survives.
- A transfer with rd == 0 completes normally (ready obeys the same rule) but is not enqueued.
- Drain: when `count` > 0 and !`wb_hold`:
  - `rd_write` = 1, `rd_addr`/`rd_data` = head entry;
  - the head is popped at the edge.
- When empty or held: `rd_write` = 0 and `rd_addr`/`rd_data` = 0.
- Enqueue and dequeue in the same cycle: `count` += enqueued − dequeued, net range −1..+2.
- `busy[r]` = OR over valid entries of (entry.rd == r). It is combinational from FIFO contents. `busy[0]` = 0 always.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - `count`, pointers = 0;
  - all stored entries discarded, no write issued;
  - after reset, `rd_write` = 0, `rd_addr` = 0, `rd_data` = 0, `busy` = 0, `alu_ready` = `mem_ready` = 1.
- Reset mid-operation drops all pending results. The reset cycle produces no register file write.
- Latency without bypass: a result accepted at edge k drives `rd_write` in the cycle after edge k and is written to the register file at edge k+1.
- `busy[rd]` rises after the accept edge and falls after the edge that pops the last entry for that rd.
- Throughput: one write per cycle, and up to two accepts per cycle while space allows.
- Full (`count` == DEPTH): both readies are 0, even if a dequeue happens that cycle.
- With `wb_hold` = 1 the FIFO fills; accepts continue until full.

## Configuration
- `WRITEBACK_BYPASS_EN` defined: when `count` == 0 and `wb_hold` = 0, the ALU result, or the mem result if ALU is not valid or rd==0, is driven straight onto `rd_*` in the same cycle and not enqueued.
  - The register file writes it at the accept edge, which is zero added latency.
  - Bypassed results never set `busy`.
  - If both channels are valid, the ALU result is bypassed and the mem result is enqueued.
- Not defined: all results go through the FIFO with 1-cycle latency.

## Test plan
- Reset, then ALU {rd=5, 0xDEAD_BEEF} for one cycle:
  - `alu_ready` = 1;
  - the next cycle shows `rd_write` = 1, `rd_addr` = 5, `rd_data` = 0xDEADBEEF, `busy[5]` = 1;
  - after that edge, `busy` = 0 and `count` = 0.
- Same cycle, ALU {rd=3, 1} and mem {rd=3, 2}:
  - both readies are 1 and `count` = 2;
  - writes appear rd3=1, then rd3=2 on consecutive cycles.
- `wb_hold` = 1 with DEPTH=4 and both channels valid every cycle (rd 1..6):
  - after 2 cycles `count` = 4 and both readies are 0;
  - with `count` = 3 and both valid, `alu_ready` = 1 and `mem_ready` = 0.
- rd = 0 on both channels: both are accepted, `count` stays 0, `rd_write` stays 0, and `busy` = 0.
- Fill 3 entries, then deassert `rst_n` for one cycle: no `rd_write` in that cycle, and afterwards `count` = 0, `busy` = 0, both readies are 1.
- With `WRITEBACK_BYPASS_EN` and the FIFO empty, ALU {rd=7, 0x55}: `rd_write` = 1 and `rd_addr` = 7 in the same cycle, `count` stays 0, `busy[7]` never set.
